// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative M-extension unit: opcode map (common with
// the ALU decode) and the sequencing FSM states.
package muldiv_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHU  = 5'b01010;
    localparam logic [4:0] OP_MULHSU = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_DIVU   = 5'b01101;
    localparam logic [4:0] OP_REM    = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/muldiv_seq_unit_if.sv
// Request/response handshake bundle between pipeline control and the mul/div unit.
interface muldiv_seq_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_opcode;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: radix-2 shift-add multiply or
// restoring shift-subtract divide on a {hi, lo} accumulator.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        // Partial remainder shifted left with the next dividend bit; borrow means restore.
        rem_sh  = acc[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (diff[XLEN]) begin
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M execute unit: PREP (sign/abs, special cases), XLEN CALC
// iterations, FIX (sign correction and result select), then DONE handshake.
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic             CLK,
    input logic             RESET,
    input logic             flush,
    muldiv_seq_unit_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, opnd_q, res_q;
    logic [TAG_W-1:0]  tag_q;
    logic [2*XLEN-1:0] acc_q, acc_next;
    logic              neg_q, neg_r;

    logic              is_div, op_ok, sign_a, sign_b, neg_a, neg_b, fast;
    logic [XLEN-1:0]   abs_a, abs_b, fast_res, fix_res;
    logic [2*XLEN-1:0] prod;

    function automatic logic [XLEN-1:0] cond_neg_x(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_2x(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div   (is_div),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (acc_next)
    );

    assign bus.in_ready   = (state_q == S_IDLE) & ~RESET & ~flush;
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.out_result = res_q;
    assign bus.out_tag    = tag_q;

    // Operand decode, signedness and the cases that bypass iteration
    always_comb begin
        is_div   = op_q[2];
        op_ok    = (op_q[4:3] == 2'b01);
        sign_a   = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
        sign_b   = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
        neg_a    = sign_a & a_q[XLEN-1];
        neg_b    = sign_b & b_q[XLEN-1];
        abs_a    = cond_neg_x(a_q, neg_a);
        abs_b    = cond_neg_x(b_q, neg_b);
        fast     = 1'b0;
        fast_res = '0;
        if (!op_ok) begin
            fast = 1'b1;
        end else if (is_div && (b_q == '0)) begin
            fast     = 1'b1;
            fast_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : a_q;
        end else if (((op_q == OP_DIV) || (op_q == OP_REM)) &&
                     (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1)) begin
            fast     = 1'b1;
            fast_res = (op_q == OP_DIV) ? a_q : '0;
        end
    end

    always_comb begin
        prod    = cond_neg_2x(acc_q, neg_q);
        fix_res = '0;
        case (op_q)
            OP_MUL:                        fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = cond_neg_x(acc_q[XLEN-1:0], neg_q);
            OP_REM, OP_REMU:               fix_res = cond_neg_x(acc_q[2*XLEN-1:XLEN], neg_r);
            default:                       fix_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.in_valid && bus.in_ready) state_d = S_PREP;
            S_PREP: state_d = fast ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q  <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            tag_q  <= '0;
            opnd_q <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid && bus.in_ready) begin
                    op_q  <= bus.in_opcode;
                    a_q   <= bus.in_a;
                    b_q   <= bus.in_b;
                    tag_q <= bus.in_tag;
                end
                S_PREP: begin
                    cnt_q <= CNT_W'(XLEN - 1);
                    neg_q <= neg_a ^ neg_b;
                    neg_r <= neg_a;
                    // Divide: dividend in lo, divisor held; multiply: multiplier in lo
                    if (is_div) begin
                        acc_q  <= {{XLEN{1'b0}}, abs_a};
                        opnd_q <= abs_b;
                    end else begin
                        acc_q  <= {{XLEN{1'b0}}, abs_b};
                        opnd_q <= abs_a;
                    end
                    if (fast) res_q <= fast_res;
                end
                S_CALC: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIX: res_q <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Scoreboard bench for muldiv_seq_unit: arithmetic table, special cases,
// backpressure, flush/reset abort and back-to-back issue.
module tb_muldiv_seq_unit;
    import muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    muldiv_seq_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    muldiv_seq_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0]  q_res[$];
    logic [TAG_W-1:0] q_tag[$];
    int               q_lat[$];

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tag;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] exp, input int lat);
        q_res.push_back(exp);
        q_tag.push_back(tag);
        q_lat.push_back(lat);
        issue(op, a, b, tag);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.out_valid) break;
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_result !== '0 || bus.out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h tag=%0d, required 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_result, bus.out_tag);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
        end
    endtask

    task automatic test_ops();
        vec_t v[$];
        int n;
        logic [XLEN-1:0] e_res;
        logic [TAG_W-1:0] e_tag, tag;
        int e_lat;
        v.push_back('{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 8'd34});
        v.push_back('{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 8'd34});
        v.push_back('{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd34});
        v.push_back('{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd34});
        v.push_back('{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 8'd34});
        v.push_back('{OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000, 8'd34});
        v.push_back('{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 8'd34});
        v.push_back('{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 8'd34});
        v.push_back('{OP_DIVU,   32'd100,      32'd7,        32'd14,       8'd34});
        v.push_back('{OP_REMU,   32'd100,      32'd7,        32'd2,        8'd34});
        v.push_back('{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 8'd34});
        v.push_back('{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        8'd34});
        v.push_back('{OP_DIV,    32'd6,        32'hFFFFFFFF, 32'hFFFFFFFA, 8'd34});
        v.push_back('{OP_DIV,    32'h80000000, 32'd2,        32'hC0000000, 8'd34});
        v.push_back('{OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 8'd34});
        v.push_back('{OP_DIVU,   32'h00001234, 32'd0,        32'hFFFFFFFF, 8'd1});
        v.push_back('{OP_DIV,    32'h00001234, 32'd0,        32'hFFFFFFFF, 8'd1});
        v.push_back('{OP_REM,    32'h00001234, 32'd0,        32'h00001234, 8'd1});
        v.push_back('{OP_REMU,   32'd5,        32'd0,        32'd5,        8'd1});
        v.push_back('{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1});
        v.push_back('{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd1});
        v.push_back('{5'b00011,  32'd9,        32'd9,        32'h00000000, 8'd1});
        for (int i = 0; i < v.size(); i++) begin
            tag = (i == 0) ? 5'd17 : 5'(i);
            send(v[i].op, v[i].a, v[i].b, tag, v[i].exp, int'(v[i].lat));
            wait_out(n);
            e_res = q_res.pop_front();
            e_tag = q_tag.pop_front();
            e_lat = q_lat.pop_front();
            n_tests++;
            if (n !== e_lat) begin
                n_fail++;
                $display("FAIL op%0d_latency (opcode %b): edges=%0d, required %0d", i, v[i].op, n, e_lat);
            end
            n_tests++;
            if (bus.out_result !== e_res) begin
                n_fail++;
                $display("FAIL op%0d_result (opcode %b a=%h b=%h): got %h, required %h",
                         i, v[i].op, v[i].a, v[i].b, bus.out_result, e_res);
            end
            n_tests++;
            if (bus.out_tag !== e_tag) begin
                n_fail++;
                $display("FAIL op%0d_tag: got %0d, required %0d", i, bus.out_tag, e_tag);
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [XLEN-1:0] e_res;
        logic [TAG_W-1:0] e_tag;
        send(OP_MUL, 32'd3, 32'd5, 5'd9, 32'd15, 34);
        wait_out(n);
        e_res = q_res.pop_front();
        e_tag = q_tag.pop_front();
        void'(q_lat.pop_front());
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== e_res || bus.out_tag !== e_tag || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: valid=%b result=%h tag=%0d in_ready=%b, required 1 %h %0d 0",
                         i, bus.out_valid, bus.out_result, bus.out_tag, bus.in_ready, e_res, e_tag);
            end
        end
        handshake();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic watch_quiet(input string name);
        int seen;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL %s_no_output: out_valid high %0d cycles, required 0", name, seen);
        end
    endtask

    task automatic test_flush();
        issue(OP_DIVU, 32'd100, 32'd7, 5'd3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready_low: in_ready=%b, required 0", bus.in_ready);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_idle: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        watch_quiet("flush");
    endtask

    task automatic test_reset_midop();
        issue(OP_MUL, 32'd11, 32'd13, 5'd4);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_tag !== '0) begin
            n_fail++;
            $display("FAIL rst_midop_idle: out_valid=%b in_ready=%b tag=%0d, required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.out_tag);
        end
        watch_quiet("rst_midop");
    endtask

    task automatic test_flush_with_valid();
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_opcode = OP_DIVU;
        bus.in_a      = 32'h1234;
        bus.in_b      = 32'd0;
        bus.in_tag    = 5'd6;
        flush         = 1'b1;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_valid_ready: in_ready=%b, required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_valid_not_accepted: in_ready=%b, required 1", bus.in_ready);
        end
        watch_quiet("flush_valid");
    endtask

    task automatic test_flush_in_done();
        int n;
        issue(OP_REMU, 32'd77, 32'd0, 5'd8);
        wait_out(n);
        n_tests++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done_reach: out_valid=%b after %0d edges, required 1", bus.out_valid, n);
        end
        @(negedge clk);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done_drop: out_valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
        end
        watch_quiet("flush_done");
    endtask

    task automatic test_back_to_back();
        int n;
        logic [XLEN-1:0] e_res;
        send(OP_DIVU, 32'd50, 32'd0, 5'd1, 32'hFFFFFFFF, 1);
        wait_out(n);
        e_res = q_res.pop_front();
        void'(q_tag.pop_front());
        void'(q_lat.pop_front());
        n_tests++;
        if (bus.out_result !== e_res) begin
            n_fail++;
            $display("FAIL b2b_first_result: got %h, required %h", bus.out_result, e_res);
        end
        handshake();
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_after_hs: in_ready=%b, required 1", bus.in_ready);
        end
        send(OP_MUL, 32'd6, 32'd7, 5'd2, 32'd42, 34);
        wait_out(n);
        e_res = q_res.pop_front();
        n_tests++;
        if (bus.out_result !== e_res || bus.out_tag !== q_tag.pop_front() || n !== q_lat.pop_front()) begin
            n_fail++;
            $display("FAIL b2b_second: result=%h tag=%0d edges=%0d, required %h 2 34",
                     bus.out_result, bus.out_tag, n, e_res);
        end
        handshake();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_ops();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_flush_with_valid();
        test_flush_in_done();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Parametrised, iterative M-extension execute unit for the RV32IM pipeline EX stage.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles.
- Uses a valid/ready handshake with the pipeline control, and carries a destination tag so writeback is steered correctly.
- Adds flush support and the exact RISC-V divide-by-zero and overflow semantics; the single-cycle ALU remains for base-ISA ops.

Parameters:
- XLEN, 32, operand/result width; must be even and at least 8.
- TAG_W, 5, width of the pass-through tag (rd index).
- CNT_W, $clog2(XLEN), iteration counter width; derived, not overridden.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- flush  in  1  abandon any in-flight operation (branch mispredict / trap).
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- in_opcode  in  5  same 5-bit ALU opcode space: 01000 MUL, 01001 MULH, 01010 MULHU, 01011 MULHSU, 01100 DIV, 01101 DIVU, 01110 REM, 01111 REMU.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the completed operation.

Behaviour:
- Reset (RESET=1 at an edge):
  - state=IDLE; out_valid=0, out_result=0, out_tag=0, all internal registers cleared.
  - in_ready=0 while RESET is high.
  - RESET mid-operation discards that operation silently.
- in_ready = (state==IDLE) & ~RESET & ~flush. Accept occurs on an edge with in_valid & in_ready; at accept, the operands, opcode and tag are registered.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
  - PREP (1 cycle):
    - Record result sign, take the absolute value of each operand per opcode signedness (MULH: both signed; MULHSU: a signed, b unsigned; MULHU/DIVU/REMU: unsigned).
    - Load counter with XLEN-1.
    - Fast path to DONE (skip CALC/FIX):
      - divisor==0: DIV/DIVU give all-ones; REM/REMU give in_a.
      - DIV/REM with a=most-negative and b=-1: DIV gives a; REM gives 0.
      - Opcode outside 01000-01111: result 0.
  - CALC (XLEN cycles, one bit per cycle, counter decrements, exits at 0):
    - Multiply: radix-2 shift-add into a 2*XLEN product register.
    - Divide: restoring shift-subtract producing quotient and remainder.
  - FIX (1 cycle):
    - Negate the product if its sign is negative; negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
    - Select the low half (MUL), the high half (MULH*), the quotient or the remainder.
  - DONE: out_valid=1; out_result and out_tag are held stable until out_ready=1. At the edge where out_valid & out_ready, go to IDLE and drop out_valid.
- Latency from the accept edge to out_valid rising:
  - XLEN+2 edges for the normal path (34 at XLEN=32).
  - 1 edge for the fast path.
- No back-to-back overlap: the next accept is possible one cycle after the handshake completes.
- Flush:
  - At any state, the next edge returns to IDLE with out_valid=0; no result is emitted for the flushed op.
  - Flush and in_valid in the same cycle: flush wins and nothing is accepted.
  - Flush in DONE while out_ready=1: flush wins and the result is dropped.
- MUL low word is identical for signed and unsigned operands. Signed overflow wraps per RISC-V; there are no exceptions and no error outputs.

Decomposition:
- Shared package muldiv_pkg holds:
  - opcode localparams (OP_MUL..OP_REMU), shared with the ALU decode;
  - the state enum (S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE).
- One sub-module, muldiv_step: combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide), parametrised by XLEN. The top level holds the FSM, counter and registers.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3): accept at edge k -> out_valid at edge k+34, out_result=0xFFFFFFEB, out_tag echoes in_tag=5'd17.
- High halves with a=b=0xFFFFFFFF: MULH -> 0x00000000, MULHSU -> 0xFFFFFFFF, MULHU -> 0xFFFFFFFE. Also MULH 0x80000000 x 0x80000000 -> 0x40000000.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- Special cases (1-cycle latency): DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x00001234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Backpressure: result ready with out_ready=0 for 5 cycles -> out_valid, out_result and out_tag stable and in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
- Flush at CALC iteration 10 -> no out_valid ever, in_ready=1 after one edge. Repeat with RESET instead of flush, and with flush+in_valid together (not accepted).
